// File: rtl/ring_injector.sv
// Ring entry stage: merges recirculating ring threads with newly injected
// threads from a buffered FIFO, with bounded starvation of the FIFO side.
module ring_injector #(
  parameter int PC_WIDTH           = 8,
  parameter int CC_ID_BITS         = 2,
  parameter int FIFO_COUNT_WIDTH   = 6,
  parameter int STARVE_LIMIT       = 3,
  parameter int STARVE_COUNT_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_inj_valid,
  input  logic [PC_WIDTH-1:0]            i_inj_pc,
  input  logic [CC_ID_BITS-1:0]          i_inj_cc_id,
  output logic                           o_inj_ready,
  input  logic                           i_ring_in_valid,
  input  logic [PC_WIDTH+CC_ID_BITS-1:0] i_ring_in_data,
  output logic                           o_ring_in_ready,
  output logic                           o_out_valid,
  output logic [PC_WIDTH+CC_ID_BITS-1:0] o_out_data,
  input  logic                           i_out_ready,
  output logic [2**CC_ID_BITS-1:0]       o_pending_chars,
  output logic                           o_idle
);

  localparam int DW    = PC_WIDTH + CC_ID_BITS;
  localparam int DEPTH = 2**FIFO_COUNT_WIDTH;
  localparam int NCC   = 2**CC_ID_BITS;
  localparam int AW    = FIFO_COUNT_WIDTH;
  localparam int SW    = STARVE_COUNT_WIDTH;
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [DW-1:0]       r_mem [DEPTH];
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [AW:0]         r_count;
  logic [SW-1:0]       r_starve_cnt;
  logic [AW:0]         r_cc_cnt [NCC];
  logic                r_out_valid;
  logic [DW-1:0]       r_out_data;

  logic                w_fifo_ne;
  logic                w_load;
  logic                w_sel_fifo;
  logic                w_push;
  logic                w_pop;
  logic                w_ring_take;
  logic [DW-1:0]       w_head;
  logic [CC_ID_BITS-1:0] w_pop_cc;
  logic [NCC-1:0]      w_cc_inc;
  logic [NCC-1:0]      w_cc_dec;

  assign w_fifo_ne   = (r_count != '0);
  assign w_head      = r_mem[r_rptr];
  assign w_pop_cc    = w_head[DW-1:PC_WIDTH];
  assign w_load      = !rst && (!r_out_valid || i_out_ready);
  // Count never exceeds DEPTH, so the MSB alone marks "full".
  assign o_inj_ready = !rst && !r_count[AW];
  assign w_push      = i_inj_valid && o_inj_ready;

  assign w_sel_fifo  = w_fifo_ne &&
                       (!i_ring_in_valid || r_starve_cnt == LIMIT);
  assign o_ring_in_ready = w_load && !w_sel_fifo;
  assign w_pop       = w_load && w_sel_fifo;
  assign w_ring_take = o_ring_in_ready && i_ring_in_valid;

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_idle      = !w_fifo_ne && !r_out_valid;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {i_inj_cc_id, i_inj_pc};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_load) begin
      r_out_valid <= w_sel_fifo || i_ring_in_valid;
      if (w_sel_fifo)           r_out_data <= w_head;
      else if (i_ring_in_valid) r_out_data <= i_ring_in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (w_pop || !w_fifo_ne) begin
      r_starve_cnt <= '0;
    end else if (w_ring_take && r_starve_cnt != LIMIT) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  always_comb begin
    w_cc_inc = '0;
    w_cc_dec = '0;
    for (int i = 0; i < NCC; i++) begin
      w_cc_inc[i] = w_push && (i_inj_cc_id == CC_ID_BITS'(i));
      w_cc_dec[i] = w_pop && (w_pop_cc == CC_ID_BITS'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCC; i++) r_cc_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NCC; i++) begin
        if (w_cc_inc[i] && !w_cc_dec[i])
          r_cc_cnt[i] <= r_cc_cnt[i] + 1'b1;
        else if (w_cc_dec[i] && !w_cc_inc[i])
          r_cc_cnt[i] <= r_cc_cnt[i] - 1'b1;
      end
    end
  end

  // A thread sitting in the output register still counts as pending.
  always_comb begin
    o_pending_chars = '0;
    for (int i = 0; i < NCC; i++) begin
      o_pending_chars[i] = (r_cc_cnt[i] != '0) ||
        (r_out_valid && r_out_data[DW-1:PC_WIDTH] == CC_ID_BITS'(i));
    end
  end

endmodule
